// File: rtl/fifo_drain.sv
// Read-side FIFO controller: credit-limited read strobes, 2-entry output buffer, valid/ack output.
// Define FIFO_DRAIN_BURST_EN to compile in fixed-length bursts with a last flag and flush.
module fifo_drain #(
  parameter int DATA_BITS  = 32,
  parameter int COUNT_BITS = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [COUNT_BITS-1:0] fifo_data_count,
  output logic                  fifo_en_r,
  input  logic [DATA_BITS-1:0]  fifo_data_r,
  input  logic                  flush,
  output logic [DATA_BITS-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ack,
  output logic                  out_last,
  output logic                  busy
);

  logic [1:0]           occ;
  logic [1:0]           occ_pop;
  logic [1:0]           held;
  logic                 vld_p1;
  logic                 last_p1;
  logic                 pop;
  logic                 credit_ok;
  logic                 burst_ok;
  logic                 tag_last;
  logic                 wr_tail;
  logic [DATA_BITS-1:0] head_data;
  logic [DATA_BITS-1:0] tail_data;
  logic                 head_last;
  logic                 tail_last;

  assign pop       = out_valid & out_ack;
  assign occ_pop   = occ - {1'b0, pop};
  // Words the buffer is committed to after this cycle's pop; never exceed two.
  assign held      = occ_pop + {1'b0, vld_p1};
  assign credit_ok = !fifo_empty && (held < 2'd2);
  assign fifo_en_r = !rst && credit_ok && burst_ok;

  // Stage p0 -> p1: read issued, data returns from the FIFO next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      occ    <= 2'd0;
    end else begin
      vld_p1 <= fifo_en_r;
      occ    <= held;
    end
  end

  always_ff @(posedge clk) begin
    last_p1 <= tag_last;
  end

  // Stage p1 -> buffer: capture behind any surviving entry so order is kept
  assign wr_tail = (occ_pop != 2'd0);

  always_ff @(posedge clk) begin
    if (pop) begin
      head_data <= tail_data;
      head_last <= tail_last;
    end
    if (vld_p1) begin
      if (wr_tail) begin
        tail_data <= fifo_data_r;
        tail_last <= last_p1;
      end else begin
        head_data <= fifo_data_r;
        head_last <= last_p1;
      end
    end
  end

  assign out_valid = (occ != 2'd0);
  assign out_data  = out_valid ? head_data : '0;
  assign out_last  = out_valid & head_last;

`ifdef FIFO_DRAIN_BURST_EN
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;
  localparam logic [COUNT_BITS-1:0] BURST_CNT = COUNT_BITS'(BURST_LEN);

  logic [1:0]            state;
  logic [COUNT_BITS-1:0] rem;

  assign burst_ok = (state == RUN);
  assign tag_last = (rem == COUNT_BITS'(1));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A full burst wins over a flush request.
          if (fifo_data_count >= BURST_CNT) begin
            rem   <= BURST_CNT;
            state <= RUN;
          end else if (flush && !fifo_empty) begin
            rem   <= fifo_data_count;
            state <= RUN;
          end
        end
        RUN: begin
          if (fifo_en_r) begin
            rem <= rem - COUNT_BITS'(1);
            if (tag_last) state <= FINISH;
          end
        end
        FINISH: begin
          if (pop && out_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_inputs;

  assign burst_ok      = 1'b1;
  assign tag_last      = 1'b0;
  assign busy          = (occ != 2'd0) | vld_p1;
  assign unused_inputs = ^{flush, fifo_data_count};
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Self-checking bench for fifo_drain: FIFO model, in-order scoreboard of words read,
// directed stream/backpressure/reset (or burst) scenarios and a randomized run.
module tb_fifo_drain;
  localparam int DATA_BITS  = 32;
  localparam int COUNT_BITS = 8;
  localparam int BURST_LEN  = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  fifo_empty = 1'b1;
  logic [COUNT_BITS-1:0] fifo_data_count = '0;
  logic                  fifo_en_r;
  logic [DATA_BITS-1:0]  fifo_data_r = '0;
  logic                  flush = 1'b0;
  logic [DATA_BITS-1:0]  out_data;
  logic                  out_valid;
  logic                  out_ack = 1'b0;
  logic                  out_last;
  logic                  busy;

  always #5 clk = ~clk;

  fifo_drain #(
    .DATA_BITS(DATA_BITS), .COUNT_BITS(COUNT_BITS), .BURST_LEN(BURST_LEN)
  ) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data_count(fifo_data_count),
    .fifo_en_r(fifo_en_r), .fifo_data_r(fifo_data_r), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ack(out_ack),
    .out_last(out_last), .busy(busy)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int pushed = 0;
  int n_en = 0;
  int first_en = -1;
  logic [DATA_BITS-1:0] fq[$];     // words held by the external FIFO
  logic [DATA_BITS-1:0] exp_q[$];  // words read from the FIFO, not yet delivered
  logic [DATA_BITS-1:0] pop_d[$];
  int                   pop_c[$];
  logic                 pop_l[$];
  logic                 prev_hold = 1'b0;
  logic [DATA_BITS-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  task automatic upd_flags();
    fifo_empty      = (fq.size() == 0);
    fifo_data_count = COUNT_BITS'(fq.size());
  endtask

  task automatic push(input logic [DATA_BITS-1:0] v);
    fq.push_back(v);
    pushed++;
    upd_flags();
  endtask

  task automatic clear_logs();
    pop_d.delete();
    pop_c.delete();
    pop_l.delete();
    n_en = 0;
    first_en = -1;
    pushed = 0;
  endtask

  // One clock cycle: observe at the falling edge, then model the FIFO after the rising edge.
  task automatic tick();
    logic en;
    logic pp;
    logic r;
    @(negedge clk);
    en = fifo_en_r;
    pp = out_valid & out_ack;
    r  = rst;
    if (r) begin
      check("rd_in_reset", fifo_en_r, 0);
    end else begin
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) check("spurious_valid", out_valid, 0);
        else check("head_data", out_data, exp_q[0]);
`ifndef FIFO_DRAIN_BURST_EN
        check("last_tied", out_last, 0);
`endif
      end
      if (pp && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        pop_d.push_back(out_data);
        pop_c.push_back(cyc);
        pop_l.push_back(out_last);
      end
      if (en) begin
        check("rd_when_empty", fifo_empty, 0);
        if (fq.size() != 0) exp_q.push_back(fq[0]);
        check("credit", exp_q.size() <= 2, 1);
        n_en++;
        if (n_en == 1) first_en = cyc;
      end
    end
    prev_hold = !r && out_valid && !out_ack;
    prev_data = out_data;
    @(posedge clk);
    #1;
    cyc++;
    if (r) exp_q.delete();
    if (en && fq.size() != 0) fifo_data_r = fq.pop_front();
    upd_flags();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    out_ack = 1'b0;
    flush = 1'b0;
    fq.delete();
    upd_flags();
    repeat (3) tick();
    rst = 1'b0;
    clear_logs();
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
  endtask

`ifndef FIFO_DRAIN_BURST_EN
  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 6; i++) push(1001 + i);
    out_ack = 1'b1;
    repeat (12) tick();
    check("stream_n", pop_d.size(), 6);
    for (int i = 0; i < 6 && i < pop_d.size(); i++) begin
      check("stream_data", pop_d[i], 1001 + i);
      check("stream_cyc", pop_c[i], first_en + 2 + i);
    end
    #1;
    check("stream_idle", out_valid, 0);
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 5; i++) push(1001 + i);
    out_ack = 1'b0;
    repeat (10) tick();
    check("bp_reads", n_en, 2);
    #1;
    check("bp_valid", out_valid, 1);
    check("bp_head", out_data, 1001);
    out_ack = 1'b1;
    for (int i = 0; i < 30 && pop_d.size() < 5; i++) tick();
    check("bp_n", pop_d.size(), 5);
    for (int i = 0; i < 5 && i < pop_d.size(); i++) check("bp_data", pop_d[i], 1001 + i);
    check("bp_reads_total", n_en, 5);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) push(1001 + i);
    out_ack = 1'b1;
    repeat (3) tick();
    check("mid_reads", n_en, 3);
    rst = 1'b1;
    out_ack = 1'b0;
    #1;
    check("mid_pre_valid", out_valid, 1);
    check("mid_en_low", fifo_en_r, 0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_valid", out_valid, 0);
    check("mid_busy", busy, 0);
    clear_logs();
    out_ack = 1'b1;
    for (int i = 0; i < 30 && pop_d.size() < 3; i++) tick();
    check("mid_n", pop_d.size(), 3);
    for (int i = 0; i < 3 && i < pop_d.size(); i++) check("mid_data", pop_d[i], 1004 + i);
  endtask

  task automatic test_random();
    int bad;
    logic [DATA_BITS-1:0] seq;
    do_reset();
    seq = 2000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 4) begin
        push(seq);
        seq++;
      end
      if ((i % 100) < 30) out_ack = ($urandom_range(0, 3) == 0);
      else out_ack = ($urandom_range(0, 3) != 0);
      tick();
    end
    out_ack = 1'b1;
    for (int i = 0; i < 400 && (fq.size() != 0 || exp_q.size() != 0); i++) tick();
    repeat (2) tick();
    check("rnd_drained", fq.size() + exp_q.size(), 0);
    check("rnd_count", pop_d.size(), pushed);
    bad = 0;
    for (int i = 0; i < pop_d.size(); i++) if (pop_d[i] != 2000 + i) bad++;
    check("rnd_order", bad, 0);
    #1;
    check("rnd_busy", busy, 0);
    check("rnd_valid", out_valid, 0);
  endtask
`else
  task automatic test_burst();
    int c_pre;
    do_reset();
    for (int i = 0; i < 6; i++) push(1001 + i);
    out_ack = 1'b1;
    c_pre = cyc;
    repeat (12) tick();
    check("b_first_en", first_en, c_pre + 1);
    check("b_reads", n_en, 4);
    check("b_n", pop_d.size(), 4);
    for (int i = 0; i < 4 && i < pop_d.size(); i++) begin
      check("b_data", pop_d[i], 1001 + i);
      check("b_last", pop_l[i], i == 3);
    end
    #1;
    check("b_idle", busy, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (8) tick();
    check("f_reads", n_en, 6);
    check("f_n", pop_d.size(), 6);
    for (int i = 4; i < 6 && i < pop_d.size(); i++) begin
      check("f_data", pop_d[i], 1001 + i);
      check("f_last", pop_l[i], i == 5);
    end
    #1;
    check("f_idle", busy, 0);
  endtask

  task automatic test_threshold();
    do_reset();
    for (int i = 0; i < 3; i++) push(1001 + i);
    out_ack = 1'b1;
    repeat (5) tick();
    check("t_noread", n_en, 0);
    #1;
    check("t_idle", busy, 0);
    push(1004);
    tick();
    #1;
    check("t_run", busy, 1);
    check("t_en", fifo_en_r, 1);
    check("t_no_early_read", n_en, 0);
    repeat (10) tick();
    check("t_n", pop_d.size(), 4);
    for (int i = 0; i < 4 && i < pop_d.size(); i++) begin
      check("t_data", pop_d[i], 1001 + i);
      check("t_last", pop_l[i], i == 3);
    end
  endtask
`endif

  initial begin
`ifndef FIFO_DRAIN_BURST_EN
    test_stream();
    test_backpressure();
    test_reset_mid();
    test_random();
`else
    test_burst();
    test_threshold();
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end
endmodule
